multicycle_arbiter: RTL

- Shares the single iterative mul/div unit in the execute stage among the 4 ALU issue lanes.
- Each cycle, every lane may present a multicycle request. The arbiter serialises the requests round-robin, starts the unit, and captures each result into a per-lane holding register.
- It asserts stall to the pipeline until every valid request in the current ereg bundle has completed. On flush it drains any in-flight operation.

---
 rtl/execute_pkg.sv | 38 +++
 rtl/rr_pick.sv | 27 ++
 rtl/multicycle_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/execute_pkg.sv
// Shared execute-stage types for the multicycle mul/div sharing logic.
package execute_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned XLEN      = 64;
    localparam int unsigned OP_W      = 4;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } mc_funct_t;

    // word selects the 32-bit (*W) variant of the operation.
    typedef struct packed {
        logic      word;
        mc_funct_t funct;
    } mc_op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } mc_state_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    pending_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] grant_o,
    output logic            any_o
);

    int unsigned idx;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr_i) + off) % N;
            if (!any_o && pending_i[idx[IdxW-1:0]]) begin
                grant_o = idx[IdxW-1:0];
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicycle_arbiter.sv
// Serialises per-lane multicycle ops onto one shared iterative mul/div unit.
// Optional MC_RESULT_BYPASS_EN exposes the result on the mc_done cycle itself.
module multicycle_arbiter
    import execute_pkg::*;
#(
    parameter int unsigned NumLanes = NUM_LANES,
    parameter int unsigned Xlen     = XLEN,
    parameter int unsigned OpW      = OP_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumLanes-1:0]      req_valid_i,
    input  logic [NumLanes*OpW-1:0]  req_op_i,
    input  logic [NumLanes*Xlen-1:0] req_a_i,
    input  logic [NumLanes*Xlen-1:0] req_b_i,
    input  logic                     advance_i,
    input  logic                     flush_i,
    output logic                     mc_start_o,
    output logic [OpW-1:0]           mc_op_o,
    output logic [Xlen-1:0]          mc_a_o,
    output logic [Xlen-1:0]          mc_b_o,
    input  logic                     mc_done_i,
    input  logic [Xlen-1:0]          mc_result_i,
    output logic [NumLanes-1:0]      res_valid_o,
    output logic [NumLanes*Xlen-1:0] res_data_o,
    output logic                     stall_o
);

    localparam int unsigned IdxW = (NumLanes > 1) ? $clog2(NumLanes) : 1;

    typedef logic [IdxW-1:0] idx_t;

    mc_state_t state_q, state_d;
    idx_t      grant_q, grant_d;
    idx_t      rr_ptr_q, rr_ptr_d;
    idx_t      pick_idx;
    logic      pick_any;

    logic [NumLanes-1:0]           done_q, done_d;
    logic [NumLanes-1:0]           pending;
    logic [NumLanes-1:0][Xlen-1:0] res_q, res_d;
    logic [OpW-1:0]                op_q, op_d;
    logic [Xlen-1:0]               a_q, a_d;
    logic [Xlen-1:0]               b_q, b_d;

    logic grant_fire;
    logic capture;

    assign pending = req_valid_i & ~done_q;

    rr_pick #(
        .N    (NumLanes),
        .IdxW (IdxW)
    ) u_rr_pick (
        .pending_i (pending),
        .ptr_i     (rr_ptr_q),
        .grant_o   (pick_idx),
        .any_o     (pick_any)
    );

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A flush never aborts the unit; in-flight work is drained.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any && !flush_i) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = flush_i ? StDrain : StWait;
            end
            StWait: begin
                if (mc_done_i) begin
                    state_d = StIdle;
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mc_done_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs and datapath strobes
    always_comb begin
        mc_start_o = (state_q == StIssue);
        grant_fire = (state_q == StIdle) && pick_any && !flush_i;
        capture    = (state_q == StWait) && mc_done_i && !flush_i;
    end

    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        done_d   = done_q;

        // Operands are captured once at grant; the unit sees them stable until done.
        if (grant_fire) begin
            grant_d = pick_idx;
            op_d    = req_op_i[pick_idx*OpW +: OpW];
            a_d     = req_a_i[pick_idx*Xlen +: Xlen];
            b_d     = req_b_i[pick_idx*Xlen +: Xlen];
        end

        if (capture) begin
            res_d[grant_q]  = mc_result_i;
            done_d[grant_q] = 1'b1;
            rr_ptr_d        = idx_t'(wrap_inc(32'(grant_q), NumLanes));
        end

        if (flush_i || advance_i) begin
            done_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            done_q   <= '0;
        end else begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        mc_op_o = op_q;
        mc_a_o  = a_q;
        mc_b_o  = b_q;
    end

`ifdef MC_RESULT_BYPASS_EN
    logic [NumLanes-1:0] hit_mask;

    // The lane completing this cycle is forwarded so the bundle can retire a cycle early.
    always_comb begin
        hit_mask = '0;
        if (capture) begin
            hit_mask[grant_q] = 1'b1;
        end
        res_valid_o = done_q | hit_mask;
        res_data_o  = '0;
        for (int unsigned l = 0; l < NumLanes; l++) begin
            res_data_o[l*Xlen +: Xlen] = hit_mask[l] ? mc_result_i : res_q[l];
        end
        stall_o = (|(pending & ~hit_mask)) && !flush_i;
    end
`else
    always_comb begin
        res_valid_o = done_q;
        res_data_o  = '0;
        for (int unsigned l = 0; l < NumLanes; l++) begin
            res_data_o[l*Xlen +: Xlen] = res_q[l];
        end
        stall_o = (|pending) && !flush_i;
    end
`endif

endmodule
